instruction_loader: RTL and testbench

Sequential writer for the 1024-word instruction memory: accepts a program as a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them to consecutive word locations starting at byte address 0. It sits between the testbench/host byte source and the instruction memory's write port, and holds the processor off (`Busy`) until the image is loaded. It also keeps a running 32-bit checksum of the loaded words for image verification.

---
 rtl/instruction_loader_if.sv | 19 +
 rtl/instruction_loader.sv | 78 +++++++
 tb/tb_instruction_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/instruction_loader_if.sv
// instruction_loader_if: host byte stream, memory write port and status of the instruction loader
interface instruction_loader_if #(parameter int COUNT_W = 11);
   logic               start;
   logic [COUNT_W-1:0] word_count;
   logic [7:0]         byte_in;
   logic               byte_valid;
   logic               byte_ready;
   logic               mem_write;
   logic [31:0]        mem_address;
   logic [31:0]        mem_data;
   logic               busy;
   logic               done;
   logic               error;
   logic [31:0]        checksum;
   modport master (output start, word_count, byte_in, byte_valid,
                   input byte_ready, mem_write, mem_address, mem_data, busy, done, error, checksum);
   modport slave (input start, word_count, byte_in, byte_valid,
                  output byte_ready, mem_write, mem_address, mem_data, busy, done, error, checksum);
endinterface

// File: rtl/instruction_loader.sv
// instruction_loader: assembles a big-endian byte stream into words and writes them to instruction memory from address 0
module instruction_loader #(
   parameter int DEPTH_WORDS = 1024,
   parameter int COUNT_W     = 11
) (
   input logic clk,
   input logic rst,
   instruction_loader_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, RECV = 2'd1, WRITE = 2'd2, DONE = 2'd3;
   logic [1:0]         state;
   logic [1:0]         bidx;
   logic [COUNT_W-1:0] cnt;
   logic [COUNT_W-1:0] widx;
   logic [23:0]        asm_bytes;
   logic               xfer;
   logic               legal;
   logic               last;
   assign xfer  = state == RECV && bus.byte_valid && bus.byte_ready;
   assign legal = bus.word_count != '0 && bus.word_count <= COUNT_W'(DEPTH_WORDS);
   assign last  = widx == cnt - COUNT_W'(1);
   // every output is a register so the memory and processor see glitch-free strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         bidx            <= '0;
         cnt             <= '0;
         widx            <= '0;
         asm_bytes       <= '0;
         bus.byte_ready  <= 1'b0;
         bus.mem_write   <= 1'b0;
         bus.mem_address <= '0;
         bus.mem_data    <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.error       <= 1'b0;
         bus.checksum    <= '0;
      end else begin
         bus.mem_write <= 1'b0;
         bus.done      <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               if (legal) begin
                  state          <= RECV;
                  cnt            <= bus.word_count;
                  widx           <= '0;
                  bidx           <= '0;
                  bus.checksum   <= '0;
                  bus.error      <= 1'b0;
                  bus.busy       <= 1'b1;
                  bus.byte_ready <= 1'b1;
               end else
                  bus.error <= 1'b1;
            end
            RECV: if (xfer) begin
               asm_bytes <= {asm_bytes[15:0], bus.byte_in};
               bidx      <= bidx + 2'd1;
               if (bidx == 2'd3) begin
                  state           <= WRITE;
                  bus.byte_ready  <= 1'b0;
                  bus.mem_write   <= 1'b1;
                  bus.mem_address <= 32'({widx, 2'b00});
                  bus.mem_data    <= {asm_bytes, bus.byte_in};
               end
            end
            WRITE: begin
               bus.checksum   <= bus.checksum + bus.mem_data;
               widx           <= widx + COUNT_W'(1);
               state          <= last ? DONE : RECV;
               bus.byte_ready <= !last;
               bus.busy       <= !last;
               bus.done       <= last;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed and random loads checked against a word-list/checksum reference model
module tb_instruction_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instruction_loader_if #(.COUNT_W(11)) bus();
   instruction_loader #(.DEPTH_WORDS(1024), .COUNT_W(11)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_assert = 0, n_fail = 0;
   int cyc = 0, acc = 0, acc_base = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
   logic [31:0] img [1024];
   logic [31:0] exp_sum = '0;
   logic [31:0] wa[$], wd[$];
   int wacc[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && bus.byte_valid && bus.byte_ready) acc <= acc + 1;
   end

   // observed memory writes and done pulses, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.mem_write) begin
         wa.push_back(bus.mem_address);
         wd.push_back(bus.mem_data);
         wacc.push_back(acc - acc_base);
      end
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_flags"}, {bus.byte_ready, bus.mem_write, bus.busy, bus.done, bus.error}, 0);
      chk({tag, "_addr"}, bus.mem_address, 0);
      chk({tag, "_data"}, bus.mem_data, 0);
      chk({tag, "_checksum"}, bus.checksum, 0);
   endtask

   task automatic load(input int n, input int stall, input bit poke, input bit timed);
      logic [31:0] w;
      int g;
      bit to = 0;
      wa.delete(); wd.delete(); wacc.delete();
      done_cnt = 0;
      acc_base = acc;
      exp_sum = '0;
      for (int k = 0; k < n; k++) exp_sum += img[k];
      @(negedge clk); bus.start = 1'b1; bus.word_count = 11'(n);
      @(negedge clk); bus.start = 1'b0; start_cyc = cyc;
      for (int i = 0; i < n * 4 && !to; i++) begin
         w = img[i / 4];
         bus.byte_valid = 1'b1;
         bus.byte_in = w[31 - 8 * (i % 4) -: 8];
         g = 0;
         while (!bus.byte_ready && g < 100) begin
            @(negedge clk);
            g++;
         end
         to = g >= 100;
         @(negedge clk);
         if (poke) begin
            bus.start = i == 0;
            bus.word_count = 11'd5;
         end
         bus.byte_valid = 1'b0;
         repeat (stall) @(negedge clk);
      end
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("byte_ready_timeout", to, 0);
      chk("write_count", wa.size(), n);
      for (int k = 0; k < wa.size() && k < n; k++) begin
         chk("write_addr", wa[k], 4 * k);
         chk("write_data", wd[k], img[k]);
         chk("bytes_before_write", wacc[k], 4 * (k + 1));
      end
      chk("checksum", bus.checksum, exp_sum);
      chk("done_pulses", done_cnt, 1);
      chk("busy_after", bus.busy, 0);
      chk("error_after", bus.error, 0);
      if (timed) chk("done_latency", done_cyc - start_cyc, 5 * n);
   endtask

   task automatic illegal(input logic [10:0] wc);
      wa.delete();
      @(negedge clk); bus.start = 1'b1; bus.word_count = wc;
      @(negedge clk); bus.start = 1'b0;
      chk("illegal_error", bus.error, 1);
      chk("illegal_busy_ready", {bus.busy, bus.byte_ready}, 0);
      repeat (4) @(negedge clk);
      chk("illegal_no_write", wa.size(), 0);
      chk("illegal_checksum_kept", bus.checksum, exp_sum);
   endtask

   initial begin
      bus.start = 1'b0; bus.word_count = '0; bus.byte_in = '0; bus.byte_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle_zero("reset");
      rst = 1'b0;
      img[0] = 32'h20080005; img[1] = 32'h8C090004;
      load(2, 0, 0, 1);
      chk("directed_checksum", bus.checksum, 32'hAC110009);
      load(2, 3, 0, 0);
      illegal(11'd0);
      illegal(11'd1025);
      img[0] = $urandom;
      load(1, 0, 0, 1);
      // abort a word after two bytes; nothing may reach memory
      wa.delete();
      @(negedge clk); bus.start = 1'b1; bus.word_count = 11'd1;
      @(negedge clk); bus.start = 1'b0; bus.byte_valid = 1'b1; bus.byte_in = 8'hAA;
      @(negedge clk); bus.byte_in = 8'h55;
      @(negedge clk); bus.byte_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk_idle_zero("midword_reset");
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("midword_no_write", wa.size(), 0);
      for (int k = 0; k < 3; k++) img[k] = $urandom;
      load(3, 1, 0, 0);
      img[0] = $urandom;
      load(1, 1, 1, 0);
      img[0] = 32'hFFFFFFFF; img[1] = 32'h00000002;
      load(2, 0, 0, 1);
      chk("wrap_checksum", bus.checksum, 32'h00000001);
      for (int r = 0; r < 4; r++) begin
         int n, s;
         n = $urandom_range(1, 6);
         s = $urandom_range(0, 2);
         for (int k = 0; k < n; k++) img[k] = $urandom;
         load(n, s, 0, s == 0);
      end
      for (int k = 0; k < 1024; k++) img[k] = $urandom;
      load(1024, 0, 0, 1);
      chk("full_last_addr", wa.size() > 0 ? wa[wa.size() - 1] : 32'hFFFFFFFF, 32'hFFC);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
